fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: word index loaded into the program counter on reset.
REQ-002 SHALL have parameter MEM_DEPTH, default 128: number of 32-bit instruction words; legal indices 0..MEM_DEPTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: downstream not ready; hold the fetch stage.
REQ-006 SHALL have port branch_valid, input, 1 bit: redirect the program counter this cycle.
REQ-007 SHALL have port branch_target, input, 32 bits: word index to redirect to.
REQ-008 SHALL have port imem_addr, output, 32 bits: word index driven to the instruction memory's combinational read address.
REQ-009 SHALL have port imem_data, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-010 SHALL have port instr, output, 32 bits: registered instruction word for the decode stage.
REQ-011 SHALL have port instr_pc, output, 32 bits: word index that instr was fetched from.
REQ-012 SHALL have port instr_valid, output, 1 bit: instr/instr_pc hold a live instruction.
REQ-013 SHALL have port fault, output, 1 bit: sticky out-of-range fetch flag.
REQ-014 SHALL have port fetch_count, output, 32 bits: number of instructions issued since reset.

Function
REQ-015 SHALL drive imem_addr combinationally from the pc register, with no added delay.
REQ-016 SHALL implement states BOOT, RUN, HALT; BOOT lasts exactly one cycle and then goes to RUN; in BOOT, pc, instr and instr_pc hold and instr_valid=0.
REQ-017 SHALL, in RUN with branch_valid=0, stall=0 and pc<MEM_DEPTH, latch instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, and fetch_count<=fetch_count+1.
REQ-018 SHALL give one-cycle latency: the word at index A appears on instr on the edge that ends the cycle in which pc==A.
REQ-019 SHALL, in RUN with stall=1 and branch_valid=0, hold pc, instr, instr_pc, instr_valid and fetch_count.
REQ-020 SHALL give branch_valid=1 in RUN priority over stall: pc<=branch_target, instr_valid<=0, instr and instr_pc hold, fetch_count holds.
REQ-021 SHALL accept a branch_target at or above MEM_DEPTH without error; the fault is raised only when that pc is fetched.
REQ-022 SHALL, in RUN with branch_valid=0, stall=0 and pc>=MEM_DEPTH, set fault<=1, instr_valid<=0, hold pc, and go to HALT.
REQ-023 SHALL, in HALT, ignore stall and branch_valid; pc, instr, instr_pc and fetch_count hold; instr_valid=0; fault=1. HALT is left only by reset.
REQ-024 SHALL wrap pc+1 and fetch_count+1 modulo 2^32, with no saturation.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, force pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fault=0, fetch_count=0, state=BOOT.
REQ-026 SHALL let reset asserted mid-stall, mid-branch or in HALT abort everything immediately; the first edge after release is the BOOT cycle.

Verification
REQ-027 SHALL be checked with: memory words 0..3 = 04100000, 04181002, 00800008, 00811008; release reset with stall=0 -> instr_valid rises 2 edges after release; instr = 04100000, 04181002, 00800008, 00811008 on consecutive edges with instr_pc = 0, 1, 2, 3; fetch_count = 4.
REQ-028 SHALL be checked with: stall=1 for 3 cycles while instr_pc=1 -> instr=04181002, instr_pc=1, pc=2 and fetch_count stay constant; fetching resumes at index 2 after stall drops.
REQ-029 SHALL be checked with: branch_valid=1, branch_target=10, stall=1 in the same cycle -> next edge gives pc=10 and instr_valid=0; the following unstalled edge gives instr_pc=10.
REQ-030 SHALL be checked with: branch_target=127 -> index 127 is issued, then pc=128 -> fault=1, instr_valid=0, pc=128 holds; a later branch_valid=1 with branch_target=0 leaves fault=1 and pc=128.
REQ-031 SHALL be checked with: reset pulsed asynchronously between clock edges during HALT -> all outputs at their reset values at once; after release, one BOOT cycle, then the fetch at RESET_PC.
REQ-032 SHALL be checked with: pc preloaded via branch to 32'hFFFF_FFFF with MEM_DEPTH=2^32 override -> fetch at FFFF_FFFF; next pc=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: drives a combinational instruction memory from
// the program counter and registers the returned word for decode.
module fetch_unit #(
  parameter logic [31:0]     RESET_PC  = 32'h0000_0000,
  parameter longint unsigned MEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instrPc;
  logic        r_instrValid;
  logic        r_fault;
  logic [31:0] r_fetchCount;

  logic [31:0] w_pcNext;
  logic [31:0] w_instrNext;
  logic [31:0] w_instrPcNext;
  logic        w_instrValidNext;
  logic        w_faultNext;
  logic [31:0] w_fetchCountNext;
  logic        w_inRange;

  // Widened compare so a MEM_DEPTH of 2^32 makes every pc legal.
  assign w_inRange = (64'(r_pc) < 64'(MEM_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0;
      r_instrPc    <= 32'h0;
      r_instrValid <= 1'b0;
      r_fault      <= 1'b0;
      r_fetchCount <= 32'h0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_instr      <= w_instrNext;
      r_instrPc    <= w_instrPcNext;
      r_instrValid <= w_instrValidNext;
      r_fault      <= w_faultNext;
      r_fetchCount <= w_fetchCountNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_instrNext      = r_instr;
    w_instrPcNext    = r_instrPc;
    w_instrValidNext = r_instrValid;
    w_faultNext      = r_fault;
    w_fetchCountNext = r_fetchCount;

    case (r_state)
      BOOT: begin
        w_stateNext      = RUN;
        w_instrValidNext = 1'b0;
      end
      RUN: begin
        // A redirect wins over stall; the fetched slot is squashed.
        if (branch_valid) begin
          w_pcNext         = branch_target;
          w_instrValidNext = 1'b0;
        end else if (!stall) begin
          if (!w_inRange) begin
            w_faultNext      = 1'b1;
            w_instrValidNext = 1'b0;
            w_stateNext      = HALT;
          end else begin
            w_instrNext      = imem_data;
            w_instrPcNext    = r_pc;
            w_instrValidNext = 1'b1;
            w_pcNext         = r_pc + 32'd1;
            w_fetchCountNext = r_fetchCount + 32'd1;
          end
        end
      end
      HALT: begin
        w_instrValidNext = 1'b0;
        w_faultNext      = 1'b1;
      end
      default: begin
        w_stateNext      = BOOT;
        w_instrValidNext = 1'b0;
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instrPc;
  assign instr_valid = r_instrValid;
  assign fault       = r_fault;
  assign fetch_count = r_fetchCount;

endmodule
